uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmit engine with a configurable-depth transmit FIFO and per-frame format control. Supported formats: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits, and line-break generation. It sits between the APB register file, which writes bytes and drives the format controls, and the TX pin. The bit clock is a one-cycle `baud_tick` strobe from the shared baud generator. It replaces the fixed-format single-holding-register transmitter.

## Interface
- `FIFO_DEPTH`, default 16: TX FIFO entries. Must be a power of two and ≥ 1. A value of 1 gives holding-register behaviour.
- `LVL_W`, default $clog2(FIFO_DEPTH)+1: width of `fifo_level`. Derived; never overridden.
- `clk` input, 1 bit: system clock.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `baud_tick` input, 1 bit: single-`clk` strobe, once per bit period.
- `wr_en` input, 1 bit: push `wr_data` into the FIFO.
- `wr_data` input, 8 bits: byte to send, LSB first. Unused MSBs are ignored.
- `data_len` input, 2 bits: 00=5, 01=6, 10=7, 11=8 data bits.
- `parity_en` input, 1 bit: insert a parity bit after the data bits.
- `odd_n_even` input, 1 bit: 1=odd parity, 0=even parity.
- `stop2` input, 1 bit: 1=two stop bits, 0=one stop bit.
- `send_break` input, 1 bit: level request to hold the line low.
- `tx` output, 1 bit: serial line. Idle high.
- `busy` output, 1 bit: engine is not in IDLE.
- `full` output, 1 bit: FIFO holds `FIFO_DEPTH` entries.
- `empty` output, 1 bit: FIFO holds 0 entries.
- `fifo_level` output, `LVL_W` bits: current FIFO occupancy.
- `overflow` output, 1 bit: one-cycle pulse when a write is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `fifo_level`=0, `overflow`=0. FIFO pointers and state are cleared.
- Reset mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and FIFO contents are discarded.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- All state changes and `tx` updates happen only on `clk` edges where `baud_tick`=1. The FIFO operates every `clk`.
- IDLE:
  - On a tick with `send_break`=1, go to BREAK. Break has priority over pending data.
  - Otherwise, on a tick with `empty`=0:
    - pop the FIFO head into the shift register;
    - latch `data_len`, `parity_en`, `odd_n_even` and `stop2` for the whole frame;
    - drive `tx`=0 and go to START.
- START: on the next tick, drive bit 0 and go to DATA with the bit counter at 1.
- DATA:
  - Each tick drives the next bit and accumulates the running XOR of the bits sent.
  - After the last data bit, go to PARITY if `parity_en` is set, otherwise to STOP1.
- PARITY: drive `odd_n_even` XOR data-XOR.
- STOP1: drive 1.
  - If `stop2` is set, go to STOP2 on the next tick.
  - Otherwise return to IDLE.
- STOP2: drive 1 for one more bit period, then return to IDLE.
- Back-to-back frames: if the FIFO is non-empty at the end of the final stop bit, the IDLE tick immediately starts the next frame. This gives no extra idle bit.
- BREAK:
  - `tx`=0 for as long as `send_break`=1 is sampled on ticks.
  - The first tick with `send_break`=0 drives 1 and enters STOP1 with `stop2` forced to 0. This guarantees at least one high bit after a break.
- Format inputs changed mid-frame have no effect until the next frame starts.
- FIFO write handling:
  - `wr_en` with `full`=0: accepted.
  - `wr_en` with `full`=1 and a pop in the same cycle: accepted, and the level is unchanged.
  - `wr_en` with `full`=1 and no pop: dropped, and `overflow` pulses high for 1 cycle.
- Simultaneous push and pop at any other level leaves `fifo_level` unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- `full`, `empty` and `fifo_level` are registered and reflect a push or pop on the next `clk` edge.
- Write-to-line latency: a byte written at edge k into an empty, idle engine causes `tx` to fall at the first `baud_tick` edge at or after k+1.
- Frame length in ticks = 1 + N + P + S, where N is the data length, P is `parity_en` (0 or 1), and S is 1 + `stop2`.
- `busy` rises on the START edge. It falls on the tick that leaves STOP1 or STOP2 into IDLE, unless a new frame starts on that same tick.
- The pop happens on the same edge as START entry. A write in that same cycle therefore sees the freed slot.

## Structure
- Shared package `uart_pkg`:
  - the state enum;
  - `data_len` encodings, with a function mapping the code to N;
  - parity-mode constants, shared with the RX side.
- Sub-module `uart_tx_fifo`:
  - parameter `FIFO_DEPTH`; ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `level`, `overflow`;
  - first-word-fall-through, so `dout` is the head without a read delay.
- The top level holds the FSM, shift register, bit counter, parity accumulator and latched format.

## Test plan
- 8N1, write 0xA5, tick every 16 clk:
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, i.e. 10 ticks;
  - then `busy`=0 and `empty`=1.
- 7E2, write 0x35: `tx` is start 0, data 1,0,1,0,1,1,0, parity 0, stop 1,1.
- 5O1, write 0x1F: data 1,1,1,1,1, parity 0, stop 1. With even parity instead, the parity bit is 1.
- `FIFO_DEPTH`=4, ticks held off, 5 writes:
  - `full`=1 after the 4th write;
  - the 5th write produces a single `overflow` pulse and is dropped;
  - enabling ticks yields exactly 4 back-to-back frames with no idle gap.
- `send_break` asserted for 20 ticks while data is queued:
  - `tx`=0 for 20 ticks, then 1 stop bit;
  - the queued frame follows.
- Assert `reset_n`=0 during DATA of a 0x5A frame: `tx`=1 and `empty`=1 immediately, with no residual bits after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX engine states, data-length codes and parity modes.
// The parity-mode constants are also used by the receive side.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;
    localparam logic [2:0] ST_BREAK  = 3'd6;

    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic [3:0] data_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO for the UART transmitter.
// A write into a full FIFO is still accepted when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] next_level;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign next_level = level + LVL_W'(do_push) - LVL_W'(do_pop);
    assign dout       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            level    <= next_level;
            full     <= (next_level == LVL_W'(FIFO_DEPTH));
            empty    <= (next_level == '0);
            overflow <= push && !do_push;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit engine: FIFO-fed, per-frame format (5-8 data bits, parity, 1/2 stop), line break.
// The line only changes on baud_tick edges; the FIFO runs every clock.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             baud_tick,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       data_len,
    input  logic             parity_en,
    input  logic             odd_n_even,
    input  logic             stop2,
    input  logic             send_break,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    logic [2:0] state;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       par_acc;
    logic [1:0] len_l;
    logic       par_en_l;
    logic       odd_l;
    logic       stop2_l;
    logic [7:0] head;
    logic       idle_slot;
    logic       start_frame;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (wr_en),
        .pop      (start_frame),
        .din      (wr_data),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

    // The final stop bit's tick doubles as the IDLE tick so queued frames run back-to-back.
    assign idle_slot   = (state == ST_IDLE) || (state == ST_STOP2) ||
                         ((state == ST_STOP1) && !stop2_l);
    assign start_frame = baud_tick && idle_slot && !send_break && !empty;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            len_l    <= LEN_5;
            par_en_l <= 1'b0;
            odd_l    <= PARITY_EVEN;
            stop2_l  <= 1'b0;
        end else if (baud_tick) begin
            if (idle_slot) begin
                if (send_break) begin
                    state <= ST_BREAK;
                    tx    <= 1'b0;
                end else if (!empty) begin
                    shift    <= head;
                    len_l    <= data_len;
                    par_en_l <= parity_en;
                    odd_l    <= odd_n_even;
                    stop2_l  <= stop2;
                    tx       <= 1'b0;
                    state    <= ST_START;
                end else begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_START: begin
                        tx      <= shift[0];
                        par_acc <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= 4'd1;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == data_bits(len_l)) begin
                            if (par_en_l) begin
                                tx    <= odd_l ^ par_acc;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP1;
                            end
                        end else begin
                            tx      <= shift[0];
                            par_acc <= par_acc ^ shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        tx    <= 1'b1;
                        state <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        tx    <= 1'b1;
                        state <= ST_STOP2;
                    end
                    ST_BREAK: begin
                        if (!send_break) begin
                            tx      <= 1'b1;
                            stop2_l <= 1'b0;
                            state   <= ST_STOP1;
                        end else begin
                            tx <= 1'b0;
                        end
                    end
                    default: begin
                        tx    <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
